knn_vote_reader: RTL and testbench
==================================

# knn_vote_reader

Read-out end of the KNN neighbour list. After the insertion control unit finishes a test point, this block walks the K-entry neighbour list and builds a per-class histogram of the stored labels. It then picks the majority label and returns it to the CPU over the peripheral read handshake. It sits between the neighbour-list storage and the CPU register interface, and only reads the list, never writes it.

## Interface
Parameters:
- K, 10: neighbour-list depth (entries 0..K-1).
- LABEL_W, 4: label width; NC = 2**LABEL_W classes.
- IDX_W, $clog2(K): neighbour index width.
- CNT_W, $clog2(K+1): histogram counter width (holds 0..K).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse: neighbour list final, begin vote.
- nb_addr  out  IDX_W  neighbour-list read index.
- nb_label  in  LABEL_W  label at nb_addr, combinational read (same cycle).
- nb_occ  in  1  entry at nb_addr is occupied.
- rd_valid  in  1  CPU read request.
- rd_ready  out  1  read response strobe, 1 cycle.
- rdata  out  32  read response word.
- busy  out  1  high in SCAN and VOTE.
- done  out  1  result held, not yet consumed.

## Operation
- States: IDLE, SCAN, VOTE, DONE. Reset -> IDLE.
- IDLE, start=1:
  - Clear all NC histogram counters.
  - Set idx=0, best_lbl=0, best_cnt=0.
  - Go to SCAN.
  - start outside IDLE is ignored.
- SCAN:
  - nb_addr=idx.
  - If nb_occ, hist[nb_label] += 1.
  - idx increments each cycle.
  - After idx==K-1 is processed, go to VOTE with cls=0.
  - Unoccupied entries are skipped but still take one cycle.
- VOTE, one class per cycle:
  - If hist[cls] > best_cnt (strictly greater), then best_cnt=hist[cls] and best_lbl=cls.
  - Ties keep the lower label.
  - After cls==NC-1, go to DONE.
- DONE: done=1; best_lbl and best_cnt frozen.
- Read port, accepted in any state:
  - rd_valid sampled at edge t -> rd_ready=1 and rdata valid during cycle t+1 only.
  - rdata[31] = done at the time of sampling.
  - rdata[23:16] = best_cnt, zero-extended.
  - rdata[15:0] = best_lbl, zero-extended.
  - Other bits are 0.
  - rdata holds its last value when rd_ready=0.
- Read in DONE consumes the result: state -> IDLE, done -> 0 at the same edge. Response still has bit31=1.
- Read in IDLE, SCAN or VOTE: response bit31=0, no state change, scan/vote continues undisturbed.
- rd_valid held high: one response per sampled cycle; at most one carries bit31=1.
- start and rd_valid in the same cycle while in DONE: read wins (result consumed, -> IDLE), start ignored.
- No occupied entries: result label 0, count 0, bit31=1.
- Counter arithmetic: CNT_W bits, never overflows since total increments ≤ K. Comparison is unsigned.

## Timing
- Reset values:
  - state=IDLE; nb_addr=0; rd_ready=0; rdata=0; busy=0; done=0.
  - Histogram, best_lbl and best_cnt are all 0.
- start sampled at edge E0:
  - SCAN occupies cycles after E0..E0+K-1.
  - VOTE occupies the next NC cycles.
  - done rises after edge E0+K+NC. Total latency is K+NC+1 edges (defaults: 27).
- busy high exactly in SCAN and VOTE.
- nb_addr is registered, valid the full cycle; nb_label/nb_occ are sampled at the end of that cycle.
- rst mid-SCAN or mid-VOTE: immediate return to reset values, partial result discarded, pending read response dropped.

## Test plan
- Reset, then K=4, LABEL_W=2, labels {2,1,2,3} all occupied, start -> done after 9 edges; read returns 0x8002_0002, then done=0 and state IDLE.
- Tie, K=4, labels {3,1,1,3} -> label 1, count 2 (0x8002_0001). Lower label wins.
- Occupancy {1,0,0,0} with labels {2,2,2,2} -> 0x8001_0002. With nb_occ all 0 -> 0x8000_0000.
- Read during SCAN -> rdata[31]=0, busy stays 1, done arrives on the same cycle as in the no-read case. Then second read -> bit31=1, and a third read -> bit31=0.
- start pulsed during VOTE is ignored (result unchanged). start and rd_valid together in DONE -> result returned, no new scan (busy stays 0).
- rst asserted mid-VOTE -> all outputs 0 immediately. New start after release yields a correct fresh result with no stale histogram counts.

Source files
------------

// File: rtl/knn_vote_reader.sv
// Read-out end of the KNN neighbour list: histograms the K stored labels,
// votes for the majority class and serves the result over the CPU read handshake.
module knn_vote_reader #(
    parameter int K       = 10,
    parameter int LABEL_W = 4,
    parameter int IDX_W   = $clog2(K),
    parameter int CNT_W   = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IDX_W-1:0]   nb_addr,
    input  logic [LABEL_W-1:0] nb_label,
    input  logic               nb_occ,
    input  logic               rd_valid,
    output logic               rd_ready,
    output logic [31:0]        rdata,
    output logic               busy,
    output logic               done
);

    localparam int NC = 2 ** LABEL_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_VOTE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   hist_r [NC];
    logic [LABEL_W-1:0] cls_r;
    logic [LABEL_W-1:0] best_lbl_r;
    logic [CNT_W-1:0]   best_cnt_r;

    logic               hist_clr_s;
    logic               hist_inc_s;
    logic [CNT_W-1:0]   cls_cnt_s;
    logic               vote_win_s;
    logic [31:0]        resp_s;

    // Response word: flag in bit 31, count in [23:16], label in [15:0].
    function automatic logic [31:0] pack_resp(
        input logic               flag,
        input logic [CNT_W-1:0]   cnt,
        input logic [LABEL_W-1:0] lbl
    );
        logic [31:0] w;
        w        = 32'h0000_0000;
        w[31]    = flag;
        w[23:16] = 8'(cnt);
        w[15:0]  = 16'(lbl);
        return w;
    endfunction

    // Decode histogram controls, the vote comparison and the response word.
    always_comb begin
        hist_clr_s = 1'b0;
        hist_inc_s = 1'b0;
        if (state_r == ST_IDLE) begin
            hist_clr_s = start;
        end else if (state_r == ST_SCAN) begin
            hist_inc_s = nb_occ;
        end else begin
            hist_clr_s = 1'b0;
        end
        cls_cnt_s  = hist_r[cls_r];
        vote_win_s = (cls_cnt_s > best_cnt_r);
        resp_s     = pack_resp(done, best_cnt_r, best_lbl_r);
    end

    // Per-class histogram: cleared on vote start, bumped by occupied entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                hist_r[i] <= '0;
            end
        end else if (hist_clr_s) begin
            for (int i = 0; i < NC; i++) begin
                hist_r[i] <= '0;
            end
        end else if (hist_inc_s) begin
            hist_r[nb_label] <= hist_r[nb_label] + CNT_W'(1);
        end
    end

    // CPU read port: one response per sampled request, data held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ready <= 1'b0;
            rdata    <= 32'h0000_0000;
        end else begin
            rd_ready <= rd_valid;
            if (rd_valid) begin
                rdata <= resp_s;
            end
        end
    end

    // Sequencing FSM: scan the list, vote one class per cycle, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            nb_addr    <= '0;
            cls_r      <= '0;
            best_lbl_r <= '0;
            best_cnt_r <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        nb_addr    <= '0;
                        cls_r      <= '0;
                        best_lbl_r <= '0;
                        best_cnt_r <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (nb_addr == IDX_W'(K - 1)) begin
                        nb_addr <= '0;
                        cls_r   <= '0;
                        state_r <= ST_VOTE;
                    end else begin
                        nb_addr <= nb_addr + IDX_W'(1);
                    end
                end
                ST_VOTE: begin
                    // Strict compare: on a tie the lower label, seen first, stays.
                    if (vote_win_s) begin
                        best_cnt_r <= cls_cnt_s;
                        best_lbl_r <= cls_r;
                    end
                    if (cls_r == LABEL_W'(NC - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cls_r <= cls_r + LABEL_W'(1);
                    end
                end
                ST_DONE: begin
                    if (rd_valid) begin
                        done    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    knn_vote_reader_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .busy     (busy),
        .done     (done)
    );

endmodule

// Protocol invariants of the vote reader outputs.
module knn_vote_reader_chk (
    input logic clk,
    input logic rst,
    input logic rd_valid,
    input logic rd_ready,
    input logic busy,
    input logic done
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_resp_follows_req: assert property (@(posedge clk) disable iff (rst) rd_ready |-> $past(rd_valid));

endmodule

// File: tb/tb_knn_vote_reader.sv
// Directed table-driven bench for knn_vote_reader with K=4, LABEL_W=2,
// plus hand sequences for reads mid-scan, start mid-vote and reset mid-vote.
module tb_knn_vote_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  nb_addr;
    logic [1:0]  nb_label;
    logic        nb_occ;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rdata;
    logic        busy;
    logic        done;

    logic [7:0]  lbl_bits;
    logic [3:0]  occ_bits;

    int errors;
    int checks;

    typedef struct packed {
        logic [7:0]  lbls;
        logic [3:0]  occ;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    knn_vote_reader #(
        .K       (4),
        .LABEL_W (2),
        .IDX_W   (2),
        .CNT_W   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .nb_addr  (nb_addr),
        .nb_label (nb_label),
        .nb_occ   (nb_occ),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neighbour-list model: combinational read at nb_addr.
    always_comb begin
        nb_label = lbl_bits[nb_addr*2 +: 2];
        nb_occ   = occ_bits[nb_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vote(output int edges);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic do_read(output logic [31:0] w, output logic rdy);
        @(negedge clk);
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        w   = rdata;
        rdy = rd_ready;
    endtask

    initial begin
        int          e;
        logic [31:0] w;
        logic        rdy;

        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rd_valid = 1'b0;
        lbl_bits = 8'h00;
        occ_bits = 4'h0;

        // entries listed {e3,e2,e1,e0}
        vecs[0] = '{lbls: {2'd3, 2'd2, 2'd1, 2'd2}, occ: 4'b1111, exp: 32'h8002_0002};
        vecs[1] = '{lbls: {2'd3, 2'd1, 2'd1, 2'd3}, occ: 4'b1111, exp: 32'h8002_0001};
        vecs[2] = '{lbls: {2'd2, 2'd2, 2'd2, 2'd2}, occ: 4'b0001, exp: 32'h8001_0002};
        vecs[3] = '{lbls: {2'd2, 2'd2, 2'd2, 2'd2}, occ: 4'b0000, exp: 32'h8000_0000};
        vecs[4] = '{lbls: {2'd3, 2'd3, 2'd3, 2'd3}, occ: 4'b1111, exp: 32'h8004_0003};
        vecs[5] = '{lbls: {2'd3, 2'd2, 2'd1, 2'd0}, occ: 4'b1111, exp: 32'h8001_0000};
        vecs[6] = '{lbls: {2'd1, 2'd3, 2'd2, 2'd3}, occ: 4'b1110, exp: 32'h8001_0001};

        repeat (2) @(negedge clk);
        chk("reset_nb_addr", 32'(nb_addr), 32'h0);
        chk("reset_rd_ready", 32'(rd_ready), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            lbl_bits = vecs[i].lbls;
            occ_bits = vecs[i].occ;
            run_vote(e);
            chk($sformatf("vec%0d_latency", i), 32'(e), 32'd9);
            chk($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'h0);
            do_read(w, rdy);
            chk($sformatf("vec%0d_rd_ready", i), 32'(rdy), 32'h1);
            chk($sformatf("vec%0d_rdata", i), w, vecs[i].exp);
            chk($sformatf("vec%0d_done_after_read", i), 32'(done), 32'h0);
            @(negedge clk);
            chk($sformatf("vec%0d_rd_ready_drop", i), 32'(rd_ready), 32'h0);
            chk($sformatf("vec%0d_rdata_hold", i), rdata, vecs[i].exp);
        end

        // Read during SCAN: not-done response, vote timing unchanged.
        lbl_bits = vecs[0].lbls;
        occ_bits = vecs[0].occ;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rd_valid = 1'b1;
        e        = 1;
        @(negedge clk);
        rd_valid = 1'b0;
        e        = 2;
        chk("scan_read_ready", 32'(rd_ready), 32'h1);
        chk("scan_read_rdata", rdata, 32'h0000_0000);
        chk("scan_read_busy", 32'(busy), 32'h1);
        while (done !== 1'b1 && e < 64) begin
            @(negedge clk);
            e++;
        end
        chk("scan_read_latency", 32'(e), 32'd9);
        do_read(w, rdy);
        chk("scan_second_read", w, 32'h8002_0002);
        do_read(w, rdy);
        chk("scan_third_read", w, 32'h0002_0002);
        chk("scan_third_ready", 32'(rdy), 32'h1);

        // start during VOTE is ignored; start+read in DONE: read wins.
        lbl_bits = vecs[1].lbls;
        occ_bits = vecs[1].occ;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e     = 1;
        while (e < 6) begin
            @(negedge clk);
            e++;
        end
        chk("vote_busy_mid", 32'(busy), 32'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e++;
        while (done !== 1'b1 && e < 64) begin
            @(negedge clk);
            e++;
        end
        chk("vote_start_latency", 32'(e), 32'd9);
        repeat (3) @(negedge clk);
        chk("vote_start_done_held", 32'(done), 32'h1);
        chk("vote_start_busy_low", 32'(busy), 32'h0);
        start    = 1'b1;
        rd_valid = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rd_valid = 1'b0;
        chk("both_rd_ready", 32'(rd_ready), 32'h1);
        chk("both_rdata", rdata, 32'h8002_0001);
        chk("both_done", 32'(done), 32'h0);
        chk("both_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("both_busy_later", 32'(busy), 32'h0);

        // Reset mid-VOTE with a response in flight, then a fresh vote.
        lbl_bits = vecs[4].lbls;
        occ_bits = vecs[4].occ;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e     = 1;
        while (e < 5) begin
            @(negedge clk);
            e++;
        end
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_vote_nb_addr", 32'(nb_addr), 32'h0);
        chk("rst_vote_rd_ready", 32'(rd_ready), 32'h0);
        chk("rst_vote_rdata", rdata, 32'h0);
        chk("rst_vote_busy", 32'(busy), 32'h0);
        chk("rst_vote_done", 32'(done), 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        lbl_bits = vecs[1].lbls;
        occ_bits = vecs[1].occ;
        run_vote(e);
        chk("post_rst_latency", 32'(e), 32'd9);
        do_read(w, rdy);
        chk("post_rst_rdata", w, 32'h8002_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
